// File: rtl/inst_mem_loader.sv
// Loads a byte-streamed program into instruction memory as little-endian 32-bit words
// and keeps the CPU held until the whole program has arrived with a matching checksum.
module inst_mem_loader #(
  parameter int          MEM_BYTES = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold,
  output logic [15:0] words_loaded
);

  localparam logic [16:0] MAX_WORDS = 17'(MEM_BYTES / 4);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] len;
  logic [15:0] word_idx;
  logic [15:0] word_idx_inc;
  logic [15:0] len_full;
  logic [1:0]  lane;
  logic [7:0]  chk;
  logic [23:0] lanes;
  logic        accept;

  always_comb begin
    state_nxt    = state;
    byte_ready   = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                   (state == S_DATA)   || (state == S_CHK);
    accept       = byte_valid && byte_ready;
    len_full     = {byte_in, len[7:0]};
    word_idx_inc = word_idx + 16'd1;
    wr_en        = (state == S_WRITE);
    busy         = byte_ready || (state == S_WRITE);
    done         = (state == S_DONE);
    error        = (state == S_ERR);
    cpu_hold     = (state != S_DONE);
    words_loaded = word_idx;
    case (state)
      S_IDLE, S_DONE, S_ERR:
        if (start) state_nxt = S_LEN_LO;
      S_LEN_LO:
        if (accept) state_nxt = S_LEN_HI;
      S_LEN_HI:
        if (accept) begin
          if ({1'b0, len_full} > MAX_WORDS) state_nxt = S_ERR;
          else if (len_full == 16'd0)       state_nxt = S_CHK;
          else                              state_nxt = S_DATA;
        end
      S_DATA:
        if (accept && lane == 2'd3) state_nxt = S_WRITE;
      S_WRITE:
        state_nxt = (word_idx_inc == len) ? S_CHK : S_DATA;
      S_CHK:
        if (accept) state_nxt = (byte_in == chk) ? S_DONE : S_ERR;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      len      <= '0;
      word_idx <= '0;
      lane     <= '0;
      chk      <= '0;
      lanes    <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE, S_DONE, S_ERR:
          if (start) begin
            word_idx <= '0;
            lane     <= '0;
            chk      <= '0;
          end
        S_LEN_LO:
          if (accept) len[7:0] <= byte_in;
        S_LEN_HI:
          if (accept) len[15:8] <= byte_in;
        S_DATA:
          if (accept) begin
            chk  <= chk ^ byte_in;
            lane <= lane + 2'd1;
            case (lane)
              2'd0: lanes[7:0]   <= byte_in;
              2'd1: lanes[15:8]  <= byte_in;
              2'd2: lanes[23:16] <= byte_in;
              default: begin
                // address and data are registered here so they stay stable outside WRITE
                wr_data <= {byte_in, lanes};
                wr_addr <= BASE_ADDR + {14'd0, word_idx, 2'b00};
              end
            endcase
          end
        S_WRITE:
          word_idx <= word_idx_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: table of complete loads plus hand-written
// sequences for ignored start, oversize length, maximum length and mid-load reset.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst, start, byte_valid, byte_ready, wr_en;
  logic [7:0]  byte_in;
  logic [31:0] wr_addr, wr_data;
  logic        busy, done, error, cpu_hold;
  logic [15:0] words_loaded;

  inst_mem_loader #(.MEM_BYTES(1024), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]  s [0:11];
    int          n;
    int          gap;
    int          nw;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        dn;
    logic        er;
    logic [15:0] wl;
  } vec_t;

  wr_t  wq[$];
  vec_t vecs [0:4];
  int   n_cmp = 0;
  int   n_err = 0;
  int   gap_not_ready = 0;
  int   both_set = 0;

  always @(negedge clk) begin
    if (wr_en === 1'b1) wq.push_back('{addr: wr_addr, data: wr_data});
    if (done === 1'b1 && error === 1'b1) both_set++;
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    byte_valid = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      if (byte_ready !== 1'b1) gap_not_ready++;
    end
    byte_in    = b;
    byte_valid = 1'b1;
    t = 0;
    while (byte_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (byte_ready !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: byte %h not accepted within 20 cycles", b);
      byte_valid = 1'b0;
    end else begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk1("start_busy", busy, 1'b1);
    chk1("start_hold", cpu_hold, 1'b1);
    chk1("start_done", done, 1'b0);
    chk1("start_error", error, 1'b0);
    chk32("start_words", 32'(words_loaded), 32'd0);
  endtask

  task automatic check_reset_vals(input string nm);
    chk1({nm, "_wr_en"}, wr_en, 1'b0);
    chk32({nm, "_wr_addr"}, wr_addr, 32'h0);
    chk32({nm, "_wr_data"}, wr_data, 32'h0);
    chk1({nm, "_busy"}, busy, 1'b0);
    chk1({nm, "_done"}, done, 1'b0);
    chk1({nm, "_error"}, error, 1'b0);
    chk1({nm, "_hold"}, cpu_hold, 1'b1);
    chk32({nm, "_words"}, 32'(words_loaded), 32'd0);
    chk1({nm, "_ready"}, byte_ready, 1'b0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  b;
    logic [7:0]  x;
    logic [31:0] last_word;
    int          qn;

    // Two-word program 0x8000060A, 0x04010800; XOR of its eight data bytes is 0x81.
    vecs[0].s = '{8'h02, 8'h00, 8'h0A, 8'h06, 8'h00, 8'h80, 8'h00, 8'h08, 8'h01, 8'h04, 8'h81, 8'h00};
    vecs[0].n = 11; vecs[0].gap = 0; vecs[0].nw = 2;
    vecs[0].d0 = 32'h8000060A; vecs[0].d1 = 32'h04010800;
    vecs[0].dn = 1'b1; vecs[0].er = 1'b0; vecs[0].wl = 16'd2;
    vecs[1] = vecs[0];
    vecs[1].gap = 3;
    vecs[2] = vecs[0];
    vecs[2].s[10] = 8'h00;
    vecs[2].dn = 1'b0; vecs[2].er = 1'b1;
    vecs[3].s = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3].n = 3; vecs[3].gap = 0; vecs[3].nw = 0;
    vecs[3].d0 = 32'h0; vecs[3].d1 = 32'h0;
    vecs[3].dn = 1'b1; vecs[3].er = 1'b0; vecs[3].wl = 16'd0;
    // Runs right after the zero-length DONE, so it is also the reload case.
    vecs[4].s = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[4].n = 7; vecs[4].gap = 1; vecs[4].nw = 1;
    vecs[4].d0 = 32'h44332211; vecs[4].d1 = 32'h0;
    vecs[4].dn = 1'b1; vecs[4].er = 1'b0; vecs[4].wl = 16'd1;

    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    chk1("idle_done", done, 1'b0);
    chk1("idle_hold", cpu_hold, 1'b1);

    for (int v = 0; v < 5; v++) begin
      wq.delete();
      gap_not_ready = 0;
      pulse_start();
      for (int k = 0; k < vecs[v].n; k++) send_byte(vecs[v].s[k], vecs[v].gap);
      chk1($sformatf("v%0d_done", v), done, vecs[v].dn);
      chk1($sformatf("v%0d_error", v), error, vecs[v].er);
      chk1($sformatf("v%0d_hold", v), cpu_hold, !vecs[v].dn);
      chk1($sformatf("v%0d_busy", v), busy, 1'b0);
      chk32($sformatf("v%0d_words", v), 32'(words_loaded), 32'(vecs[v].wl));
      chk32($sformatf("v%0d_nwrites", v), 32'(wq.size()), 32'(vecs[v].nw));
      chk32($sformatf("v%0d_gap_ready", v), 32'(gap_not_ready), 32'd0);
      if (vecs[v].nw > 0 && wq.size() > 0) begin
        chk32($sformatf("v%0d_addr0", v), wq[0].addr, 32'h0);
        chk32($sformatf("v%0d_data0", v), wq[0].data, vecs[v].d0);
      end
      if (vecs[v].nw > 1 && wq.size() > 1) begin
        chk32($sformatf("v%0d_addr1", v), wq[1].addr, 32'h4);
        chk32($sformatf("v%0d_data1", v), wq[1].data, vecs[v].d1);
      end
    end

    // start pulsed while collecting data bytes must not restart the load
    wq.delete();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk1("ign_busy", busy, 1'b1);
    chk1("ign_ready", byte_ready, 1'b1);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_byte(8'h44, 0);
    chk1("ign_done", done, 1'b1);
    chk32("ign_nwrites", 32'(wq.size()), 32'd1);
    if (wq.size() > 0) chk32("ign_data", wq[0].data, 32'h44332211);

    // 257 words exceeds the 256-word memory
    wq.delete();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    chk1("over_error", error, 1'b1);
    chk1("over_done", done, 1'b0);
    chk1("over_hold", cpu_hold, 1'b1);
    chk1("over_busy", busy, 1'b0);
    chk32("over_words", 32'(words_loaded), 32'd0);
    byte_in = 8'h5A;
    byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk1("over_ready", byte_ready, 1'b0);
    byte_valid = 1'b0;
    chk32("over_nwrites", 32'(wq.size()), 32'd0);

    // exactly 256 words is the largest legal program
    wq.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    chk1("max_not_error", error, 1'b0);
    x = 8'h00;
    last_word = 32'h0;
    for (int k = 0; k < 1024; k++) begin
      b = 8'((k * 7 + 3) & 255);
      x = x ^ b;
      last_word = {b, last_word[31:8]};
      send_byte(b, 0);
    end
    send_byte(x, 0);
    chk1("max_done", done, 1'b1);
    chk32("max_words", 32'(words_loaded), 32'd256);
    chk32("max_nwrites", 32'(wq.size()), 32'd256);
    if (wq.size() == 256) begin
      chk32("max_last_addr", wq[255].addr, 32'h3FC);
      chk32("max_last_data", wq[255].data, last_word);
    end

    // reset right after the sixth stream byte aborts the load
    wq.delete();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h0A, 0);
    send_byte(8'h06, 0);
    send_byte(8'h00, 0);
    send_byte(8'h80, 0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    qn = wq.size();
    byte_in = 8'h00;
    byte_valid = 1'b1;
    repeat (6) @(negedge clk);
    byte_valid = 1'b0;
    chk32("midrst_no_write", 32'(wq.size()), 32'(qn));
    chk1("midrst_idle_busy", busy, 1'b0);

    chk32("done_error_exclusive", 32'(both_set), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
